// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - enable, counter value and display outputs of the 7-segment scanner
//
// Signals:
//   en          scan enable (master -> slave)
//   count_in    4*DIGITS-bit binary value, nibble k shown on digit k (master -> slave)
//   seg_n       active-low segments a..g in bits 0..6 (slave -> master)
//   dig_n       active-low digit enables (slave -> master)
//   frame_done  one-cycle pulse after each complete scan frame (slave -> master)
interface seg7_scan_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic [4*DIGITS-1:0]   count_in;
    logic [6:0]            seg_n;
    logic [DIGITS-1:0]     dig_n;
    logic                  frame_done;

    modport master (
        output en,
        output count_in,
        input  seg_n,
        input  dig_n,
        input  frame_done
    );

    modport slave (
        input  en,
        input  count_in,
        output seg_n,
        output dig_n,
        output frame_done
    );
endinterface

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - time-multiplexed common-anode 7-segment hex scanner with per-frame snapshot
//
// Parameters: DIGITS (1..8), PRESCALE (clk cycles per digit slot, >= 2),
//             BLANK (all-off cycles at the start of each slot, < PRESCALE).
// Ports:
//   clk        system clock, rising edge
//   neg_reset  asynchronous active-low reset
//   bus        seg7_scan_if.slave: en, count_in in; seg_n, dig_n, frame_done out
// Optional feature: define SEG7_SCAN_LZB_EN for leading-zero blanking.
module seg7_scan #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1024,
    parameter int BLANK    = 16
) (
    input  logic        clk,
    input  logic        neg_reset,
    seg7_scan_if.slave  bus
);
    localparam int PW = $clog2(PRESCALE);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DIDX_LAST = DW'(DIGITS - 1);

    logic [PW-1:0]         pcnt;
    logic [DW-1:0]         didx;
    logic [4*DIGITS-1:0]   snap;

    logic [3:0]            cur_nib;
    logic [DIGITS-1:0]     cur_dig_n;
    logic                  in_blank;
    logic                  suppress;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            default: hex_seg = 7'h0E;
        endcase
    endfunction

    // Select the current digit's nibble and one-cold enable with a compare
    // loop rather than a computed part-select, so DW-wide index arithmetic
    // cannot overflow.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dig_n = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (didx == DW'(k)) begin
                cur_nib      = snap[4*k +: 4];
                cur_dig_n[k] = 1'b0;
            end
        end
    end

    // Signed compare so BLANK=0 simply never blanks.
    assign in_blank = int'(pcnt) < BLANK;

`ifdef SEG7_SCAN_LZB_EN
    logic upper_zero;

    // Walk from the most significant digit down; upper_zero at step k means
    // nibbles DIGITS-1..k are all zero. Digit 0 is never suppressed.
    always_comb begin
        upper_zero = 1'b1;
        suppress   = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (snap[4*k +: 4] != 4'h0)
                upper_zero = 1'b0;
            if (didx == DW'(k))
                suppress = upper_zero;
        end
    end
`else
    assign suppress = 1'b0;
`endif

    always_ff @(posedge clk or negedge neg_reset) begin
        if (!neg_reset) begin
            pcnt           <= '0;
            didx           <= '0;
            snap           <= '0;
            bus.seg_n      <= 7'h7F;
            bus.dig_n      <= '1;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            if (bus.en) begin
                if (in_blank || suppress) begin
                    bus.seg_n <= 7'h7F;
                    bus.dig_n <= '1;
                end else begin
                    bus.seg_n <= hex_seg(cur_nib);
                    bus.dig_n <= cur_dig_n;
                end

                if (pcnt == PCNT_LAST) begin
                    pcnt <= '0;
                    if (didx == DIDX_LAST) begin
                        // Frame end: take a new snapshot so the next frame
                        // is drawn from one consistent value.
                        didx           <= '0;
                        snap           <= bus.count_in;
                        bus.frame_done <= 1'b1;
                    end else begin
                        didx <= didx + 1'b1;
                    end
                end else begin
                    pcnt <= pcnt + 1'b1;
                end
            end else begin
                // Display off, timers and snapshot frozen.
                bus.seg_n <= 7'h7F;
                bus.dig_n <= '1;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - self-checking bench for seg7_scan (three configurations against a reference model)
module tb_seg7_scan;
    localparam int PD [3] = '{2, 4, 1};
    localparam int PP [3] = '{4, 4, 3};
    localparam int PB [3] = '{1, 1, 0};
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        neg_reset;
    logic        en;
    logic [15:0] cin;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg7_scan_if #(.DIGITS(2)) if0 ();
    seg7_scan_if #(.DIGITS(4)) if1 ();
    seg7_scan_if #(.DIGITS(1)) if2 ();

    assign if0.en = en;
    assign if1.en = en;
    assign if2.en = en;
    assign if0.count_in = cin[7:0];
    assign if1.count_in = cin[15:0];
    assign if2.count_in = cin[3:0];

    seg7_scan #(.DIGITS(2), .PRESCALE(4), .BLANK(1)) u0 (.clk(clk), .neg_reset(neg_reset), .bus(if0.slave));
    seg7_scan #(.DIGITS(4), .PRESCALE(4), .BLANK(1)) u1 (.clk(clk), .neg_reset(neg_reset), .bus(if1.slave));
    seg7_scan #(.DIGITS(1), .PRESCALE(3), .BLANK(0)) u2 (.clk(clk), .neg_reset(neg_reset), .bus(if2.slave));

    logic [6:0] oseg [3];
    logic [7:0] odig [3];
    logic       ofd  [3];
    assign oseg[0] = if0.seg_n;
    assign oseg[1] = if1.seg_n;
    assign oseg[2] = if2.seg_n;
    assign odig[0] = {6'h3F, if0.dig_n};
    assign odig[1] = {4'hF, if1.dig_n};
    assign odig[2] = {7'h7F, if2.dig_n};
    assign ofd[0]  = if0.frame_done;
    assign ofd[1]  = if1.frame_done;
    assign ofd[2]  = if2.frame_done;

    // Reference model: n counts enabled cycles since reset; slot position,
    // digit and frame boundaries follow from plain division.
    int          mn   [3];
    logic [15:0] ms   [3];
    logic [6:0]  eseg [3];
    logic [7:0]  edig [3];
    logic        efd  [3];

    function automatic bit m_off(int i, int n, logic [15:0] s);
        int pc;
        int di;
        logic [15:0] hi;
        pc = n % PP[i];
        di = (n / PP[i]) % PD[i];
        hi = s >> (4 * di);
        if (pc < PB[i]) return 1'b1;
`ifdef SEG7_SCAN_LZB_EN
        if (di > 0 && hi == 16'h0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [6:0] m_seg(int i, int n, logic [15:0] s);
        logic [15:0] hi;
        hi = s >> (4 * ((n / PP[i]) % PD[i]));
        if (m_off(i, n, s)) return 7'h7F;
        return HEX[hi[3:0]];
    endfunction

    function automatic logic [7:0] m_dig(int i, int n, logic [15:0] s);
        if (m_off(i, n, s)) return 8'hFF;
        return ~(8'd1 << ((n / PP[i]) % PD[i]));
    endfunction

    always @(posedge clk or negedge neg_reset) begin
        for (int i = 0; i < 3; i++) begin
            if (!neg_reset) begin
                mn[i]   <= 0;
                ms[i]   <= '0;
                eseg[i] <= 7'h7F;
                edig[i] <= 8'hFF;
                efd[i]  <= 1'b0;
            end else if (en) begin
                eseg[i] <= m_seg(i, mn[i], ms[i]);
                edig[i] <= m_dig(i, mn[i], ms[i]);
                efd[i]  <= ((mn[i] + 1) % (PD[i] * PP[i])) == 0;
                if (((mn[i] + 1) % (PD[i] * PP[i])) == 0)
                    ms[i] <= cin & 16'((32'd1 << (4 * PD[i])) - 1);
                mn[i] <= mn[i] + 1;
            end else begin
                eseg[i] <= 7'h7F;
                edig[i] <= 8'hFF;
                efd[i]  <= 1'b0;
            end
        end
    end

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string ph);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_seg%0d", ph, i), {1'b0, oseg[i]}, {1'b0, eseg[i]});
            chk($sformatf("%s_dig%0d", ph, i), odig[i], edig[i]);
            chk($sformatf("%s_fd%0d", ph, i), {7'b0, ofd[i]}, {7'b0, efd[i]});
        end
    endtask

    task automatic tick(string ph);
        @(negedge clk);
        check_all(ph);
    endtask

    task automatic wait_fd();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            tick("wfd");
            if (if0.frame_done) found = 1'b1;
        end
        chk("wait_frame_done", {7'b0, found}, 8'd1);
    endtask

    initial begin
        neg_reset = 1'b0;
        en        = 1'b1;
        cin       = '0;

        // Reset held for three cycles
        for (int k = 0; k < 3; k++) begin
            tick("rst");
            chk("rst_seg", {1'b0, if0.seg_n}, 8'h7F);
            chk("rst_dig", {6'b0, if0.dig_n}, 8'h03);
            chk("rst_fd", {7'b0, if0.frame_done}, 8'h00);
        end
        neg_reset = 1'b1;
        tick("rel");
        chk("rel_blank_dig", {6'b0, if0.dig_n}, 8'h03);
        tick("rel");
        chk("rel_first_dig", {6'b0, if0.dig_n}, 8'h02);
        chk("rel_first_seg", {1'b0, if0.seg_n}, 8'h40);

        // Scan and decode of 0xA7
        cin = 16'($urandom()) & 16'hFF00 | 16'h00A7;
        wait_fd();
        tick("scan");
        chk("scan_blank0", {6'b0, if0.dig_n}, 8'h03);
        for (int k = 0; k < 3; k++) begin
            tick("scan");
            chk("scan_d0_dig", {6'b0, if0.dig_n}, 8'h02);
            chk("scan_d0_seg", {1'b0, if0.seg_n}, 8'h78);
            chk("scan_d0_fd", {7'b0, if0.frame_done}, 8'h00);
        end
        tick("scan");
        chk("scan_blank1", {6'b0, if0.dig_n}, 8'h03);
        for (int k = 0; k < 3; k++) begin
            tick("scan");
            chk("scan_d1_dig", {6'b0, if0.dig_n}, 8'h01);
            chk("scan_d1_seg", {1'b0, if0.seg_n}, 8'h08);
            chk("scan_d1_fd", {7'b0, if0.frame_done}, (k == 2) ? 8'h01 : 8'h00);
        end

        // Tearing: 0x12 loaded, then changed to 0x34 mid-frame
        cin = 16'h0012;
        wait_fd();
        tick("tear");
        tick("tear");
        tick("tear");
        cin = 16'h0034;
        tick("tear");
        chk("tear_d0_old", {1'b0, if0.seg_n}, 8'h24);
        tick("tear");
        chk("tear_blank", {6'b0, if0.dig_n}, 8'h03);
        for (int k = 0; k < 3; k++) begin
            tick("tear");
            chk("tear_d1_old", {1'b0, if0.seg_n}, 8'h79);
        end
        tick("tear");
        tick("tear");
        chk("tear_d0_new_dig", {6'b0, if0.dig_n}, 8'h02);
        chk("tear_d0_new_seg", {1'b0, if0.seg_n}, 8'h19);

        // Enable dropped for five cycles mid-DRIVE
        en = 1'b0;
        tick("en");
        chk("en_off_dig", {6'b0, if0.dig_n}, 8'h03);
        chk("en_off_seg", {1'b0, if0.seg_n}, 8'h7F);
        for (int k = 0; k < 4; k++) tick("en");
        en = 1'b1;
        tick("en");
        chk("en_resume_dig", {6'b0, if0.dig_n}, 8'h02);
        tick("en");
        chk("en_resume_dig2", {6'b0, if0.dig_n}, 8'h02);
        chk("en_resume_fd", {7'b0, if0.frame_done}, 8'h00);
        tick("en");
        chk("en_resume_blank", {6'b0, if0.dig_n}, 8'h03);

        // Short asynchronous reset pulse mid-slot
        begin
            bit driving;
            driving = 1'b0;
            for (int k = 0; k < 16 && !driving; k++) begin
                tick("ar");
                if (if0.dig_n != 2'b11) driving = 1'b1;
            end
            chk("ar_wait_drive", {7'b0, driving}, 8'd1);
        end
        #2 neg_reset = 1'b0;
        #1;
        check_all("ar_pulse");
        chk("ar_seg", {1'b0, if0.seg_n}, 8'h7F);
        chk("ar_dig", {6'b0, if0.dig_n}, 8'h03);
        chk("ar_fd", {7'b0, if0.frame_done}, 8'h00);
        #1 neg_reset = 1'b1;
        tick("ar");
        chk("ar_restart_blank", {6'b0, if0.dig_n}, 8'h03);
        tick("ar");
        chk("ar_restart_dig", {6'b0, if0.dig_n}, 8'h02);
        chk("ar_restart_seg", {1'b0, if0.seg_n}, 8'h40);

        // Leading-zero patterns for the four-digit instance
        cin = 16'h0050;
        for (int k = 0; k < 40; k++) tick("lzb50");
        cin = 16'h0000;
        for (int k = 0; k < 40; k++) tick("lzb00");

        // Randomised values and enable toggling
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0)
                cin = ($urandom_range(0, 2) == 0) ? (16'($urandom()) & 16'h00FF) : 16'($urandom());
            if ($urandom_range(0, 15) == 0)
                en = ~en;
            tick("rand");
        end
        en = 1'b1;
        for (int k = 0; k < 20; k++) tick("tail");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
